// File: rtl/quad_steer_decoder.sv
// -----------------------------------------------------------------------------
// quad_steer_decoder
//
// Purpose:
//   Receive-side decoder for a real steering encoder (spinner / driving wheel).
//   The raw A/B phases are synchronised, glitch-filtered and decoded as 4x
//   quadrature into a wrapping signed position, single-cycle step pulses and
//   held left/right steering levels.
//
// Parameters:
//   FILTER  - consecutive differing cycles before a filtered phase updates (>=1)
//   COUNT_W - width of the position counter
//   HOLD    - cycles a right/left level stays asserted after the last step
//   HOLD_W  - width of the hold timer (HOLD < 2**HOLD_W)
//
// Ports:
//   CLK      in   block clock
//   reset    in   asynchronous, active-high reset
//   quad_a   in   raw phase A (asynchronous to CLK)
//   quad_b   in   raw phase B (asynchronous to CLK)
//   clr      in   synchronous clear of position and err
//   position out  signed step count, wraps modulo 2**COUNT_W
//   step_r   out  one-cycle pulse per right (clockwise) transition
//   step_l   out  one-cycle pulse per left transition
//   right    out  held level while steering right
//   left     out  held level while steering left
//   err      out  sticky: both phases changed in the same cycle
// -----------------------------------------------------------------------------
module quad_steer_decoder #(
  parameter int FILTER  = 4,
  parameter int COUNT_W = 8,
  parameter int HOLD    = 22500,
  parameter int HOLD_W  = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               quad_a,
  input  logic               quad_b,
  input  logic               clr,
  output logic [COUNT_W-1:0] position,
  output logic               step_r,
  output logic               step_l,
  output logic               right,
  output logic               left,
  output logic               err
);

  // Filter run-length counter and INIT duration counter widths.
  localparam int FCW = (FILTER < 1) ? 1 : $clog2(FILTER + 1);
  localparam int ICW = $clog2(FILTER + 3);

  localparam logic [FCW-1:0]     F_LAST   = FCW'(FILTER - 1);
  localparam logic [FCW-1:0]     F_ONE    = FCW'(1);
  localparam logic [ICW-1:0]     I_LAST   = ICW'(FILTER + 2);
  localparam logic [ICW-1:0]     I_ONE    = ICW'(1);
  localparam logic [COUNT_W-1:0] P_ONE    = COUNT_W'(1);
  localparam logic [HOLD_W-1:0]  T_ONE    = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]  T_RELOAD = HOLD_W'(HOLD);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [ICW-1:0]     r_init_cnt;
  logic [1:0]         r_prev;
  logic [COUNT_W-1:0] r_pos;
  logic [HOLD_W-1:0]  r_timer;
  logic               r_step_r;
  logic               r_step_l;
  logic               r_right;
  logic               r_left;
  logic               r_err;

  logic               w_init;
  logic               w_run;
  logic [1:0]         w_raw;
  logic [1:0]         w_filt;
  logic [1:0]         w_idx_cur;
  logic [1:0]         w_idx_prev;
  logic               w_right;
  logic               w_left;
  logic               w_illegal;

  assign w_init = (r_state == ST_INIT);
  assign w_run  = (r_state == ST_RUN);
  assign w_raw  = {quad_a, quad_b};   // bit 1 = A, bit 0 = B

  // ---------------------------------------------------------------------------
  // Per-phase synchroniser and glitch filter. During INIT the filtered value
  // follows sync2 directly so the resting input level is absorbed silently.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_phase
      logic           r_sync1;
      logic           r_sync2;
      logic           r_filt;
      logic [FCW-1:0] r_cnt;

      always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_filt  <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
          if (w_init) begin
            r_filt <= r_sync2;
            r_cnt  <= '0;
          end else if (r_sync2 == r_filt) begin
            r_cnt <= '0;
          end else if (r_cnt == F_LAST) begin
            // FILTER-th consecutive differing cycle: accept the new level.
            r_filt <= r_sync2;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + F_ONE;
          end
        end
      end

      assign w_filt[gi] = r_filt;
    end
  endgenerate

  // Map the Gray-coded phase pair onto a 0..3 ring so that a right step is
  // "index + 1" and a left step "index - 1": 00->0, 10->1, 11->2, 01->3.
  function automatic logic [1:0] phase_idx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  assign w_idx_cur  = phase_idx(w_filt);
  assign w_idx_prev = phase_idx(r_prev);

  // An illegal jump differs by 2 on the ring, so it never matches +1 or -1.
  assign w_right   = w_run && (w_idx_cur == w_idx_prev + 2'd1);
  assign w_left    = w_run && (w_idx_prev == w_idx_cur + 2'd1);
  assign w_illegal = w_run && ((w_filt ^ r_prev) == 2'b11);

  // ---------------------------------------------------------------------------
  // Control FSM, decode, position counter and hold levels.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_prev     <= 2'b00;
      r_pos      <= '0;
      r_timer    <= '0;
      r_step_r   <= 1'b0;
      r_step_l   <= 1'b0;
      r_right    <= 1'b0;
      r_left     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_prev   <= w_filt;
      r_step_r <= w_right;
      r_step_l <= w_left;

      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == I_LAST) begin
            r_state <= ST_RUN;
          end else begin
            r_init_cnt <= r_init_cnt + I_ONE;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase

      if (w_illegal) begin
        r_err <= 1'b1;
      end
      if (w_right) begin
        r_pos <= r_pos + P_ONE;
      end else if (w_left) begin
        r_pos <= r_pos - P_ONE;
      end

      // clr overrides any simultaneous step or error for position and err.
      if (clr) begin
        r_pos <= '0;
        r_err <= 1'b0;
      end

      // Hold timer: a step reloads it; the level drops as it reaches zero.
      if (w_right) begin
        r_right <= 1'b1;
        r_left  <= 1'b0;
        r_timer <= T_RELOAD;
      end else if (w_left) begin
        r_left  <= 1'b1;
        r_right <= 1'b0;
        r_timer <= T_RELOAD;
      end else if (r_timer != '0) begin
        r_timer <= r_timer - T_ONE;
        if (r_timer == T_ONE) begin
          r_right <= 1'b0;
          r_left  <= 1'b0;
        end
      end
    end
  end

  assign position = r_pos;
  assign step_r   = r_step_r;
  assign step_l   = r_step_l;
  assign right    = r_right;
  assign left     = r_left;
  assign err      = r_err;

endmodule

// File: doc/quad_steer_decoder.md
Name: quad_steer_decoder

Overview:
Quadrature decoder for real steering encoders (spinner or driving wheel) wired to the user port. It is the receive-side counterpart of the joystick-to-quadrature steering generator. It takes raw asynchronous A/B phases, synchronises and glitch-filters them, and decodes 4x quadrature into three results: a wrapping signed position, single-cycle step pulses, and held left/right levels. Its outputs can drive either the game's steering inputs or the digital left/right path.

Parameters:
FILTER, 4, consecutive cycles a synchronised phase must differ from its filtered value before the filtered value updates (FILTER >= 1)
COUNT_W, 8, width of the position counter
HOLD, 22500, cycles the right/left level stays asserted after the most recent step
HOLD_W, 16, width of the hold timer (must satisfy HOLD < 2^HOLD_W)

Ports:
CLK  in  1  single clock for the block
reset  in  1  asynchronous, active-high reset
quad_a  in  1  raw phase A, asynchronous to CLK
quad_b  in  1  raw phase B, asynchronous to CLK
clr  in  1  synchronous clear of the position counter and the error flag
position  out  COUNT_W  signed two's-complement step count, wraps modulo 2^COUNT_W
step_r  out  1  one-cycle pulse per right (clockwise) transition
step_l  out  1  one-cycle pulse per left transition
right  out  1  held level, asserted while steering right
left  out  1  held level, asserted while steering left
err  out  1  sticky flag: an illegal transition occurred (both phases changed at once)

Behaviour:
- Reset (async, active-high) clears every register: sync flip-flops, filter counters, filtered phases, previous state, hold timer, position, and all outputs to 0. State goes to INIT.
- Synchroniser: two flip-flops per phase; sync2 is the second stage.
- Filter, per phase:
  - The counter clears whenever sync2 equals the filtered value.
  - It increments each cycle sync2 differs from the filtered value.
  - On the FILTER-th consecutive differing cycle, the filtered value takes sync2 and the counter clears.
- State machine, two states:
  - INIT, lasting FILTER+3 cycles after reset release: filtered values load sync2 directly with no filtering; prev loads filtered; no steps, no err, position held. Then go to RUN.
  - RUN: normal decode. It leaves RUN only on reset.
- Decode in RUN, comparing {A,B} = filtered against prev each cycle, with prev <= filtered every cycle:
  - Right sequence: 00->10->11->01->00. Each right transition gives step_r=1 for one cycle and position+1.
  - Left sequence: the exact reverse. Each left transition gives step_l=1 for one cycle and position-1.
  - No change: nothing happens.
  - Both bits changed: err<=1, position unchanged, no step.
- Latency: with a clean input edge that meets setup before clock edge 1, the step pulse and the position update are visible after clock edge FILTER+3.
- Position arithmetic is modular: 0x7F+1 gives 0x80, and 0x00-1 gives 0xFF (COUNT_W=8). No saturation.
- clr:
  - Next cycle, position=0 and err=0.
  - If clr coincides with a step, clr wins for position (result is 0). The step pulse and the hold update still occur.
- Hold levels:
  - A right step sets right=1, clears left, and loads the timer with HOLD.
  - A left step sets left=1, clears right, and loads the timer with HOLD.
  - Each cycle with no step and timer > 0, the timer decrements. The held level drops in the cycle the timer reaches 0, so it is asserted HOLD cycles after the last step.
  - right and left are never both 1.
- Filtered pulses shorter than FILTER cycles are ignored completely: no step and no err.
- Reset mid-operation aborts everything immediately, and the block re-enters INIT. The input level present at release is absorbed without a step or err.

Test Plan:
- Reset held, then released with inputs {A,B}=11 and FILTER=4 -> position=0, err=0, no step pulses during INIT (7 cycles) or afterwards.
- From 00, apply 10,11,01,00, each held 10 cycles -> four step_r pulses, position=4; each pulse appears exactly FILTER+3=7 cycles after its input change; right=1 and left=0.
- Apply the reverse sequence for 6 transitions starting from position=4 -> position=0xFE; left=1 and right=0 from the first left step; left drops HOLD cycles after the last step.
- Glitch A high for 3 cycles (FILTER=4) -> no step, no err, filtered unchanged. Then a 00->11 jump held for 10 cycles -> err=1, position unchanged. Then clr -> err=0, position=0.
- From position=0x7F, one right step -> 0x80. From 0x00, one left step -> 0xFF. clr asserted in the same cycle as a step -> position=0 and the step pulse is still seen.
- Right step then left step 5 cycles apart -> right drops in the cycle left rises; the timer reloads to HOLD; no overlap of right and left.
